issue_queue_wakeup: RTL and testbench

//  Parametrised out-of-order issue queue between rename and execute. Holds DEPTH renamed instrs.

---
 rtl/issueq_pkg.sv | 30 +++
 rtl/issueq_select.sv | 48 ++++
 rtl/issue_queue_wakeup.sv | 190 +++++++++++++++++++
 tb/tb_issue_queue_wakeup.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issueq_pkg.sv
// Purpose: shared constants for the issue queue and the execute stage: operand indices,
//          payload field offsets, and the ROB age helper used by select and partial flush.
// Latency: n/a (package). Backpressure: n/a.
package issueq_pkg;

    // Operand slots within an entry
    localparam int OP_A  = 0;
    localparam int OP_B  = 1;
    localparam int OP_ST = 2;

    // ROB sequence number width the age helper is built for
    localparam int IQ_SEQ_W = 6;

    // Opaque payload layout, decoded by execute (total 138 bits)
    localparam int PAY_FLAGS_LSB = 0;
    localparam int PAY_FLAGS_W   = 10;
    localparam int PAY_PC_LSB    = PAY_FLAGS_LSB + PAY_FLAGS_W;
    localparam int PAY_PC_W      = 64;
    localparam int PAY_INSTR_LSB = PAY_PC_LSB + PAY_PC_W;
    localparam int PAY_INSTR_W   = 32;
    localparam int PAY_IMM_LSB   = PAY_INSTR_LSB + PAY_INSTR_W;
    localparam int PAY_IMM_W     = 32;

    // Distance from the ROB head; wraps, so a smaller value is older
    function automatic logic [IQ_SEQ_W-1:0] seq_age(input logic [IQ_SEQ_W-1:0] seq,
                                                    input logic [IQ_SEQ_W-1:0] head);
        return seq - head;
    endfunction

endpackage

// File: rtl/issueq_select.sv
// Purpose: pick one entry out of a DEPTH-wide ready vector; one-hot grant plus valid.
// Latency: combinational. Backpressure: none; grant is held stable by the caller's state.
// Config:  IQ_AGE_SELECT_EN defined -> oldest (smallest age) wins; undefined -> lowest index wins.
// Ports:   req (ready per entry), age (per-entry ROB age), gnt (one-hot), gnt_vld (any grant).
module issueq_select import issueq_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int AGE_W = IQ_SEQ_W
) (
    input  logic [DEPTH-1:0]            req,
    input  logic [DEPTH-1:0][AGE_W-1:0] age,
    output logic [DEPTH-1:0]            gnt,
    output logic                        gnt_vld
);

`ifdef IQ_AGE_SELECT_EN
    logic [AGE_W-1:0] best_age;

    // Seqs are unique in the queue, so ages never tie and the winner is unambiguous
    always_comb begin
        gnt      = '0;
        gnt_vld  = 1'b0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (!gnt_vld || age[i] < best_age)) begin
                gnt      = '0;
                gnt[i]   = 1'b1;
                gnt_vld  = 1'b1;
                best_age = age[i];
            end
        end
    end
`else
    logic unused_age;
    assign unused_age = ^age;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && !gnt_vld) begin
                gnt[i]  = 1'b1;
                gnt_vld = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/issue_queue_wakeup.sv
// Purpose: out-of-order issue queue; captures operands from wakeup broadcasts, issues one ready entry/cycle.
// Latency: enq or wakeup -> earliest issue next cycle; iss_* is combinational from registered state.
// Backpressure: enq_ready from registered occupancy; iss_ready=0 holds entries (selection may move to older).
// Ports: enq_* from rename, wk_* broadcast channels, iss_* to execute, flush_* kill, occupancy count.
// Config: IQ_AGE_SELECT_EN selects oldest-first issue; otherwise lowest-index ready entry issues.
module issue_queue_wakeup import issueq_pkg::*; #(
    parameter int DEPTH    = 16,
    parameter int NUM_SRC  = 3,
    parameter int NUM_WAKE = 2,
    parameter int TAG_W    = 6,
    parameter int DATA_W   = 32,
    parameter int PAY_W    = 138,
    parameter int SEQ_W    = IQ_SEQ_W
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        enq_valid,
    output logic                        enq_ready,
    input  logic [PAY_W-1:0]            enq_payload,
    input  logic [SEQ_W-1:0]            enq_seq,
    input  logic [NUM_SRC*TAG_W-1:0]    enq_tag,
    input  logic [NUM_SRC-1:0]          enq_rdy,
    input  logic [NUM_SRC*DATA_W-1:0]   enq_val,
    input  logic [NUM_WAKE-1:0]         wk_valid,
    input  logic [NUM_WAKE*TAG_W-1:0]   wk_tag,
    input  logic [NUM_WAKE*DATA_W-1:0]  wk_val,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [PAY_W-1:0]            iss_payload,
    output logic [SEQ_W-1:0]            iss_seq,
    output logic [NUM_SRC*DATA_W-1:0]   iss_val,
    input  logic [SEQ_W-1:0]            rob_head_seq,
    input  logic                        flush_all,
    input  logic                        flush_part,
    input  logic [SEQ_W-1:0]            flush_seq,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic [PAY_W-1:0]                   pay;
        logic [SEQ_W-1:0]                   seq;
        logic [NUM_SRC-1:0][TAG_W-1:0]      tag;
        logic [NUM_SRC-1:0]                 rdy;
        logic [NUM_SRC-1:0][DATA_W-1:0]     val;
    } entry_t;

    entry_t                          ent_q [DEPTH];
    entry_t                          ent_d [DEPTH];
    entry_t                          enq_ent;
    logic [DEPTH-1:0]                vld_q, vld_d;
    logic [OCC_W-1:0]                occ_q, occ_d;
    logic [IDX_W-1:0]                enq_idx;
    logic                            enq_fire, iss_fire;
    logic [DEPTH-1:0]                req, gnt;
    logic                            gnt_vld;
    logic [DEPTH-1:0][SEQ_W-1:0]     age;
    logic [SEQ_W-1:0]                flush_age;
    logic [NUM_WAKE-1:0][TAG_W-1:0]  wk_tag_a;
    logic [NUM_WAKE-1:0][DATA_W-1:0] wk_val_a;
    logic [PAY_W-1:0]                sel_pay;
    logic [SEQ_W-1:0]                sel_seq;
    logic [NUM_SRC*DATA_W-1:0]       sel_val;

    assign wk_tag_a  = wk_tag;
    assign wk_val_a  = wk_val;
    assign flush_age = seq_age(flush_seq, rob_head_seq);

    assign enq_ready = occ_q < DEPTH_OCC;
    assign enq_fire  = enq_valid && enq_ready && !flush_all && !flush_part;
    assign iss_valid = gnt_vld && !flush_all && !flush_part;
    assign iss_fire  = iss_valid && iss_ready;
    assign occupancy = occ_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            req[i] = vld_q[i] && (&ent_q[i].rdy);
            age[i] = seq_age(ent_q[i].seq, rob_head_seq);
        end
    end

    issueq_select #(.DEPTH(DEPTH), .AGE_W(SEQ_W)) u_select (
        .req     (req),
        .age     (age),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // Lowest free slot; only consulted when registered occupancy < DEPTH
    always_comb begin
        enq_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) enq_idx = IDX_W'(i);
        end
    end

    // Incoming entry, with operands captured from this cycle's broadcasts so no wakeup is missed.
    // Channels are scanned high to low so the lowest-numbered matching channel lands last.
    always_comb begin
        enq_ent.pay = enq_payload;
        enq_ent.seq = enq_seq;
        enq_ent.tag = enq_tag;
        enq_ent.rdy = enq_rdy;
        enq_ent.val = enq_val;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!enq_rdy[k]) begin
                if (enq_ent.tag[k] == '0) begin
                    enq_ent.rdy[k] = 1'b1;
                    enq_ent.val[k] = '0;
                end
                for (int c = NUM_WAKE - 1; c >= 0; c--) begin
                    if (wk_valid[c] && wk_tag_a[c] != '0 && wk_tag_a[c] == enq_ent.tag[k]) begin
                        enq_ent.rdy[k] = 1'b1;
                        enq_ent.val[k] = wk_val_a[c];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            for (int k = 0; k < NUM_SRC; k++) begin
                if (vld_q[i] && !ent_q[i].rdy[k]) begin
                    for (int c = NUM_WAKE - 1; c >= 0; c--) begin
                        if (wk_valid[c] && wk_tag_a[c] != '0 && wk_tag_a[c] == ent_q[i].tag[k]) begin
                            ent_d[i].rdy[k] = 1'b1;
                            ent_d[i].val[k] = wk_val_a[c];
                        end
                    end
                end
            end
        end

        vld_d = vld_q;
        if (iss_fire) vld_d = vld_d & ~gnt;
        if (flush_all) begin
            vld_d = '0;
        end else if (flush_part) begin
            // The branch itself (equal age) survives; only strictly younger entries die
            for (int i = 0; i < DEPTH; i++) begin
                if (age[i] > flush_age) vld_d[i] = 1'b0;
            end
        end
        if (enq_fire) begin
            ent_d[enq_idx] = enq_ent;
            vld_d[enq_idx] = 1'b1;
        end

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OCC_W'(vld_d[i]);
    end

    always_comb begin
        sel_pay = '0;
        sel_seq = '0;
        sel_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
                sel_pay = ent_q[i].pay;
                sel_seq = ent_q[i].seq;
                sel_val = ent_q[i].val;
            end
        end
    end

    assign iss_payload = iss_valid ? sel_pay : '0;
    assign iss_seq     = iss_valid ? sel_seq : '0;
    assign iss_val     = iss_valid ? sel_val : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    // Entry contents are qualified by vld_q, so they carry no reset
    always_ff @(posedge CLK) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_issue_queue_wakeup.sv
module tb_issue_queue_wakeup;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         enq_valid, enq_ready;
    logic [137:0] enq_payload;
    logic [5:0]   enq_seq;
    logic [17:0]  enq_tag;
    logic [2:0]   enq_rdy;
    logic [95:0]  enq_val;
    logic [1:0]   wk_valid;
    logic [11:0]  wk_tag;
    logic [63:0]  wk_val;
    logic         iss_valid, iss_ready;
    logic [137:0] iss_payload;
    logic [5:0]   iss_seq;
    logic [95:0]  iss_val;
    logic [5:0]   rob_head_seq;
    logic         flush_all, flush_part;
    logic [5:0]   flush_seq;
    logic [4:0]   occupancy;

    always #5 CLK = ~CLK;

    issue_queue_wakeup dut (
        .CLK(CLK), .RESET(RESET),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
        .enq_seq(enq_seq), .enq_tag(enq_tag), .enq_rdy(enq_rdy), .enq_val(enq_val),
        .wk_valid(wk_valid), .wk_tag(wk_tag), .wk_val(wk_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .iss_seq(iss_seq), .iss_val(iss_val),
        .rob_head_seq(rob_head_seq), .flush_all(flush_all), .flush_part(flush_part),
        .flush_seq(flush_seq), .occupancy(occupancy)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]   seq;
        logic [137:0] pay;
        logic [95:0]  val;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    logic sb_en = 1'b0;

    typedef struct {
        logic [5:0]  seq;
        logic [17:0] tag;
        logic [2:0]  rdy;
        logic [95:0] val;
        logic [1:0]  ew_vld;
        logic [11:0] ew_tag;
        logic [63:0] ew_val;
        logic [1:0]  nw_vld;
        logic [11:0] nw_tag;
        logic [63:0] nw_val;
        logic        early;
        logic [95:0] exp_val;
    } vec_t;
    vec_t vt[7];

    function automatic logic [137:0] mk_pay(input logic [5:0] s);
        return {s, 100'h0, 26'h3000000, s};
    endfunction

    task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        enq_valid = 1'b0; wk_valid = '0; flush_all = 1'b0; flush_part = 1'b0;
    endtask

    task automatic drive_enq(input logic [5:0] s, input logic [17:0] t,
                             input logic [2:0] r, input logic [95:0] v);
        enq_valid = 1'b1; enq_seq = s; enq_payload = mk_pay(s);
        enq_tag = t; enq_rdy = r; enq_val = v;
    endtask

    task automatic push(input logic [5:0] s, input logic [95:0] v);
        exp_t e;
        e.seq = s; e.pay = mk_pay(s); e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 20 && occupancy != 0; i++) step();
        chk(name, occupancy, 0);
    endtask

    // Scoreboard side: every accepted issue must match the next expected instruction
    always @(negedge CLK) begin
        if (sb_en && RESET && iss_valid && iss_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL sb_unexpected: got seq %0d expected none", iss_seq);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_seq", iss_seq, mon_e.seq);
                chk("sb_pay", iss_payload, mon_e.pay);
                chk("sb_val", iss_val, mon_e.val);
            end
        end
    end

    initial begin
        vt[0] = '{seq:6'd3, tag:18'h0, rdy:3'b111, val:{32'h3, 32'h2, 32'h1},
                  ew_vld:2'b00, ew_tag:12'h0, ew_val:64'h0, nw_vld:2'b00, nw_tag:12'h0, nw_val:64'h0,
                  early:1'b1, exp_val:{32'h3, 32'h2, 32'h1}};
        vt[1] = '{seq:6'd4, tag:{6'd0, 6'd0, 6'd5}, rdy:3'b110, val:{32'h3, 32'h2, 32'h0},
                  ew_vld:2'b00, ew_tag:12'h0, ew_val:64'h0,
                  nw_vld:2'b01, nw_tag:{6'd0, 6'd5}, nw_val:{32'h0, 32'hDEAD},
                  early:1'b0, exp_val:{32'h3, 32'h2, 32'hDEAD}};
        vt[2] = '{seq:6'd5, tag:{6'd0, 6'd0, 6'd5}, rdy:3'b110, val:{32'h3, 32'h2, 32'h0},
                  ew_vld:2'b10, ew_tag:{6'd5, 6'd0}, ew_val:{32'hBEEF, 32'h0},
                  nw_vld:2'b00, nw_tag:12'h0, nw_val:64'h0,
                  early:1'b1, exp_val:{32'h3, 32'h2, 32'hBEEF}};
        vt[3] = '{seq:6'd6, tag:{6'd0, 6'd7, 6'd0}, rdy:3'b101, val:{32'h3, 32'h0, 32'h1},
                  ew_vld:2'b11, ew_tag:{6'd7, 6'd7}, ew_val:{32'h22, 32'h11},
                  nw_vld:2'b00, nw_tag:12'h0, nw_val:64'h0,
                  early:1'b1, exp_val:{32'h3, 32'h11, 32'h1}};
        vt[4] = '{seq:6'd7, tag:18'h0, rdy:3'b011, val:{32'hFFFF, 32'h2, 32'h1},
                  ew_vld:2'b00, ew_tag:12'h0, ew_val:64'h0, nw_vld:2'b00, nw_tag:12'h0, nw_val:64'h0,
                  early:1'b1, exp_val:{32'h0, 32'h2, 32'h1}};
        vt[5] = '{seq:6'd8, tag:{6'd0, 6'd4, 6'd3}, rdy:3'b100, val:{32'h3, 32'h0, 32'h0},
                  ew_vld:2'b00, ew_tag:12'h0, ew_val:64'h0,
                  nw_vld:2'b11, nw_tag:{6'd3, 6'd4}, nw_val:{32'h33, 32'h44},
                  early:1'b0, exp_val:{32'h3, 32'h44, 32'h33}};
        vt[6] = '{seq:6'd9, tag:{6'd0, 6'd0, 6'd6}, rdy:3'b111, val:{32'h3, 32'h2, 32'h55},
                  ew_vld:2'b01, ew_tag:{6'd0, 6'd6}, ew_val:{32'h0, 32'h99},
                  nw_vld:2'b00, nw_tag:12'h0, nw_val:64'h0,
                  early:1'b1, exp_val:{32'h3, 32'h2, 32'h55}};

        RESET = 1'b0; idle(); iss_ready = 1'b0; rob_head_seq = '0; flush_seq = '0;
        enq_seq = '0; enq_payload = '0; enq_tag = '0; enq_rdy = '0; enq_val = '0;
        wk_tag = '0; wk_val = '0;
        #23 RESET = 1'b1;
        step();
        chk("rst_occ", occupancy, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_iss_seq", iss_seq, 0);
        chk("rst_iss_val", iss_val, 0);
        chk("rst_iss_pay", iss_payload, 0);

        // Single-instruction vectors: readiness at enq, enq-cycle and next-cycle wakeups
        sb_en = 1'b1; iss_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            drive_enq(vt[v].seq, vt[v].tag, vt[v].rdy, vt[v].val);
            wk_valid = vt[v].ew_vld; wk_tag = vt[v].ew_tag; wk_val = vt[v].ew_val;
            push(vt[v].seq, vt[v].exp_val);
            #1 chk($sformatf("v%0d_enq_cycle_iss", v), iss_valid, 0);
            step();
            enq_valid = 1'b0;
            wk_valid = vt[v].nw_vld; wk_tag = vt[v].nw_tag; wk_val = vt[v].nw_val;
            #1 chk($sformatf("v%0d_early_iss", v), iss_valid, vt[v].early);
            chk($sformatf("v%0d_occ1", v), occupancy, 1);
            step();
            wk_valid = '0;
            wait_empty($sformatf("v%0d_drain", v));
        end

        // Fill to DEPTH, drop at full, net-zero enq+issue
        sb_en = 1'b0; iss_ready = 1'b0; rob_head_seq = 6'd20;
        for (int i = 0; i < 16; i++) begin
            drive_enq(6'(20 + i), 18'h0, 3'b111, {32'h0, 32'h0, 32'(i)});
            step();
        end
        enq_valid = 1'b0;
        chk("full_occ", occupancy, 16);
        chk("full_enq_ready", enq_ready, 0);
        chk("full_iss_seq", iss_seq, 20);
        drive_enq(6'd50, 18'h0, 3'b111, 96'h0);
        step();
        chk("full_drop_occ", occupancy, 16);
        iss_ready = 1'b1;
        #1 chk("full_iss_first", iss_seq, 20);
        step();
        chk("full_issue_enq_dropped", occupancy, 15);
        drive_enq(6'd36, 18'h0, 3'b111, 96'h0);
        #1 chk("net0_iss_seq", iss_seq, 21);
        step();
        chk("net0_occ", occupancy, 15);
        iss_ready = 1'b0;
        drive_enq(6'd37, 18'h0, 3'b111, 96'h0);
        step();
        chk("refill_occ", occupancy, 16);
        drive_enq(6'd38, 18'h0, 3'b111, 96'h0);
        flush_all = 1'b1;
        #1 chk("flush_all_iss", iss_valid, 0);
        step();
        idle();
        chk("flush_all_occ", occupancy, 0);

        // Age wrap: head 62, entries placed in slot order 1,0,63, all woken together
        rob_head_seq = 6'd62; sb_en = 1'b1;
        drive_enq(6'd1, {12'h0, 6'd9}, 3'b110, {32'h3, 32'h2, 32'h0}); step();
        drive_enq(6'd0, {12'h0, 6'd9}, 3'b110, {32'h3, 32'h2, 32'h0}); step();
        drive_enq(6'd63, {12'h0, 6'd9}, 3'b110, {32'h3, 32'h2, 32'h0}); step();
        enq_valid = 1'b0;
        chk("wrap_not_ready", iss_valid, 0);
        wk_valid = 2'b01; wk_tag = {6'd0, 6'd9}; wk_val = {32'h0, 32'h77};
        step();
        wk_valid = '0;
        chk("wrap_ready", iss_valid, 1);
`ifdef IQ_AGE_SELECT_EN
        chk("wrap_first", iss_seq, 63);
        push(6'd63, {32'h3, 32'h2, 32'h77}); push(6'd0, {32'h3, 32'h2, 32'h77});
        push(6'd1, {32'h3, 32'h2, 32'h77});
`else
        chk("wrap_first", iss_seq, 1);
        push(6'd1, {32'h3, 32'h2, 32'h77}); push(6'd0, {32'h3, 32'h2, 32'h77});
        push(6'd63, {32'h3, 32'h2, 32'h77});
`endif
        iss_ready = 1'b1;
        wait_empty("wrap_drain");

        // Partial flush: seq 10..14, kill younger than 11
        iss_ready = 1'b0; rob_head_seq = 6'd10;
        for (int i = 0; i < 5; i++) begin
            drive_enq(6'(10 + i), 18'h0, 3'b111, {32'h0, 32'h0, 32'(100 + i)});
            step();
        end
        enq_valid = 1'b0;
        chk("pf_occ5", occupancy, 5);
        chk("pf_ready", iss_valid, 1);
        flush_part = 1'b1; flush_seq = 6'd11; iss_ready = 1'b1;
        drive_enq(6'd20, 18'h0, 3'b111, 96'h0);
        #1 chk("pf_iss_gated", iss_valid, 0);
        step();
        idle(); iss_ready = 1'b0;
        chk("pf_occ2", occupancy, 2);
        push(6'd10, {32'h0, 32'h0, 32'd100}); push(6'd11, {32'h0, 32'h0, 32'd101});
        iss_ready = 1'b1;
        wait_empty("pf_drain");

        // Stall with 3 ready entries, then asynchronous reset mid-cycle
        sb_en = 1'b0; iss_ready = 1'b0; rob_head_seq = '0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(6'(40 + i), 18'h0, 3'b111, 96'h0);
            step();
        end
        enq_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_vld", c), iss_valid, 1);
            chk($sformatf("stall%0d_seq", c), iss_seq, 40);
            chk($sformatf("stall%0d_occ", c), occupancy, 3);
            step();
        end
        #2 RESET = 1'b0;
        #1 chk("arst_occ", occupancy, 0);
        chk("arst_iss_valid", iss_valid, 0);
        chk("arst_enq_ready", enq_ready, 1);
        #3 RESET = 1'b1;
        step();
        chk("post_arst_occ", occupancy, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
